gpio_apb_arb: RTL and testbench

GPIO_APB_ARB -- requirements
Module: gpio_apb_arb

---
 rtl/gpio_apb_arb.sv | 177 +++++++++++++++++
 tb/tb_gpio_apb_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_arb.sv
// gpio_apb_arb
// Two-requester round-robin arbiter that turns simple req/ack transfers into
// APB3-style cycles (no PREADY) towards a two-register GPIO slave.
//
// Ports
//   PCLK, PRESET           clock, synchronous active-high reset
//   reqN, wrN, addrN,      requester N transfer request, direction, address,
//   wdataN                 write data (N = 0, 1)
//   ackN, errN, rdataN     one-cycle completion pulse with status / read data
//   PSEL, PENABLE, PWRITE, APB master outputs
//   PADDR, PWDATA
//   PRDATA                 APB read data from the slave
//
// Transfer flow: IDLE -> SETUP -> ACCESS -> DONE [-> GAP] -> IDLE for a legal
// address. An illegal address skips the bus: IDLE -> DONE with err set.
module gpio_apb_arb #(
    parameter logic [31:0] BASE_ADDR = 32'h4004_0000,
    parameter int unsigned IDLE_GAP  = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA
);

    localparam logic [3:0]  GAP_LD   = IDLE_GAP[3:0];
    localparam bit          HAS_GAP  = (GAP_LD != 4'd0);
    localparam logic [31:0] REG1_ADR = BASE_ADDR + 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;        // requester owning the current transfer
    logic        prio_q, prio_d;      // requester that wins a tie
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  gap_q, gap_d;

    logic        pick;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a == BASE_ADDR) || (a == REG1_ADR);
    endfunction

    // Tie goes to prio_q; a lone request is granted directly.
    assign pick      = (req0 && req1) ? prio_q : req1;
    assign sel_wr    = pick ? wr1    : wr0;
    assign sel_addr  = pick ? addr1  : addr0;
    assign sel_wdata = pick ? wdata1 : wdata0;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        prio_d   = prio_q;
        wr_d     = wr_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        gap_d    = gap_q;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d  = pick;
                    prio_d = ~pick;
                    wr_d   = sel_wr;
                    if (addr_legal(sel_addr)) begin
                        // Bus registers only move on a real APB cycle so
                        // PADDR/PWDATA keep their last driven values otherwise.
                        paddr_d  = sel_addr;
                        pwdata_d = sel_wdata;
                        state_d  = S_SETUP;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                err_d   = 1'b0;
                rdata_d = wr_q ? 32'd0 : PRDATA;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (HAS_GAP) begin
                    gap_d   = GAP_LD;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            prio_q   <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            gap_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            prio_q   <= prio_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            gap_q    <= gap_d;
        end
    end

    logic done;
    assign done = (state_q == S_DONE);

    assign PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE = (state_q == S_ACCESS);
    assign PWRITE  = PSEL && wr_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

    // Completion outputs are forced to zero for the non-owning requester.
    assign ack0   = done && !gnt_q;
    assign ack1   = done &&  gnt_q;
    assign err0   = ack0 && err_q;
    assign err1   = ack1 && err_q;
    assign rdata0 = ack0 ? rdata_q : 32'd0;
    assign rdata1 = ack1 ? rdata_q : 32'd0;

endmodule

// File: tb/tb_gpio_apb_arb.sv
module tb_gpio_apb_arb;

    localparam logic [31:0] BASE = 32'h4004_0000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1, PRDATA;

    logic        a_ack0, a_ack1, a_err0, a_err1, a_psel, a_pen, a_pwrite;
    logic [31:0] a_rdata0, a_rdata1, a_paddr, a_pwdata;
    logic        b_ack0, b_ack1, b_err0, b_err1, b_psel, b_pen, b_pwrite;
    logic [31:0] b_rdata0, b_rdata1, b_paddr, b_pwdata;

    always #5 PCLK = ~PCLK;

    gpio_apb_arb #(.BASE_ADDR(BASE), .IDLE_GAP(0)) dut_a (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .err0(a_err0), .err1(a_err1),
        .rdata0(a_rdata0), .rdata1(a_rdata1),
        .PSEL(a_psel), .PENABLE(a_pen), .PWRITE(a_pwrite),
        .PADDR(a_paddr), .PWDATA(a_pwdata), .PRDATA(PRDATA)
    );

    gpio_apb_arb #(.BASE_ADDR(BASE), .IDLE_GAP(3)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .err0(b_err0), .err1(b_err1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .PSEL(b_psel), .PENABLE(b_pen), .PWRITE(b_pwrite),
        .PADDR(b_paddr), .PWDATA(b_pwdata), .PRDATA(PRDATA)
    );

    typedef struct packed {
        logic        who;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input logic who, input logic err, input logic [31:0] rd);
        exp_t e;
        e.who = who; e.err = err; e.rdata = rd;
        sb.push_back(e);
    endtask

    // Scoreboard monitor on dut_a completions.
    always @(negedge PCLK) begin
        if (mon_en && !PRESET && (a_ack0 || a_ack1)) begin
            exp_t e;
            chk("sb_single_ack", {31'd0, a_ack0 && a_ack1}, 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_ack: observed ack0=%0b ack1=%0b expected none", a_ack0, a_ack1);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_who", {31'd0, a_ack1}, {31'd0, e.who});
                chk("sb_err", {31'd0, a_ack1 ? a_err1 : a_err0}, {31'd0, e.err});
                chk("sb_rdata", a_ack1 ? a_rdata1 : a_rdata0, e.rdata);
                chk("sb_other_quiet", a_ack1 ? ({31'd0, a_err0} | a_rdata0) : ({31'd0, a_err1} | a_rdata1), 32'd0);
            end
        end
    end

    initial begin
        int nack, viol, cnt;
        bit prev, found;
        PRESET = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; PRDATA = 0;

        // Reset state
        tick(); tick();
        chk("rst_psel", {31'd0, a_psel}, 32'd0);
        chk("rst_penable", {31'd0, a_pen}, 32'd0);
        chk("rst_pwrite", {31'd0, a_pwrite}, 32'd0);
        chk("rst_paddr", a_paddr, 32'd0);
        chk("rst_pwdata", a_pwdata, 32'd0);
        chk("rst_acks", {30'd0, a_ack1, a_ack0}, 32'd0);
        chk("rst_rdata", a_rdata0 | a_rdata1, 32'd0);
        PRESET = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single write by requester 0
        req0 = 1; wr0 = 1; addr0 = BASE; wdata0 = 32'h0000_0F0F; PRDATA = 32'hFFFF_FFFF;
        push(1'b0, 1'b0, 32'd0);
        tick();
        chk("wr_setup_psel", {31'd0, a_psel}, 32'd1);
        chk("wr_setup_penable", {31'd0, a_pen}, 32'd0);
        chk("wr_setup_paddr", a_paddr, BASE);
        chk("wr_setup_pwrite", {31'd0, a_pwrite}, 32'd1);
        chk("wr_setup_pwdata", a_pwdata, 32'h0000_0F0F);
        req0 = 0; wr0 = 0; addr0 = 32'h1234_5678; wdata0 = 32'h0BAD_0BAD;
        tick();
        chk("wr_access_psel_pen", {30'd0, a_psel, a_pen}, 32'd3);
        chk("wr_access_paddr", a_paddr, BASE);
        chk("wr_access_pwdata", a_pwdata, 32'h0000_0F0F);
        chk("wr_access_pwrite", {31'd0, a_pwrite}, 32'd1);
        tick();
        chk("wr_ack_t3", {30'd0, a_ack1, a_ack0}, 32'd1);
        chk("wr_err", {31'd0, a_err0}, 32'd0);
        chk("wr_done_psel", {31'd0, a_psel}, 32'd0);
        chk("wr_done_pwrite", {31'd0, a_pwrite}, 32'd0);
        tick();
        chk("wr_ack_gone", {31'd0, a_ack0}, 32'd0);

        // Single read by requester 1
        req1 = 1; wr1 = 0; addr1 = BASE + 32'd4; wdata1 = 32'h5555_5555; PRDATA = 32'hDEAD_BEEF;
        push(1'b1, 1'b0, 32'h0005_0000);
        tick();
        chk("rd_setup", {29'd0, a_psel, a_pen, a_pwrite}, 32'd4);
        chk("rd_setup_paddr", a_paddr, BASE + 32'd4);
        req1 = 0;
        tick();
        chk("rd_access", {30'd0, a_psel, a_pen}, 32'd3);
        PRDATA = 32'h0005_0000;
        tick();
        PRDATA = 32'h0;
        chk("rd_ack_t3", {30'd0, a_ack1, a_ack0}, 32'd2);
        chk("rd_rdata", a_rdata1, 32'h0005_0000);
        tick();

        // Illegal address by requester 0
        req0 = 1; wr0 = 0; addr0 = BASE + 32'd8; PRDATA = 32'hAAAA_AAAA;
        push(1'b0, 1'b1, 32'd0);
        tick();
        chk("ill_ack_t1", {30'd0, a_ack1, a_ack0}, 32'd1);
        chk("ill_err", {31'd0, a_err0}, 32'd1);
        chk("ill_rdata", a_rdata0, 32'd0);
        chk("ill_psel", {31'd0, a_psel}, 32'd0);
        chk("ill_paddr_hold", a_paddr, BASE + 32'd4);
        req0 = 0;
        tick();
        chk("ill_idle_psel", {31'd0, a_psel | a_ack0}, 32'd0);

        // Reset during ACCESS of a requester-0 transfer
        req0 = 1; wr0 = 1; addr0 = BASE; wdata0 = 32'h0000_0011;
        tick();
        chk("rstx_setup", {31'd0, a_psel}, 32'd1);
        req0 = 0;
        tick();
        chk("rstx_access", {31'd0, a_pen}, 32'd1);
        PRESET = 1;
        tick();
        chk("rstx_bus_off", {30'd0, a_psel, a_pen}, 32'd0);
        chk("rstx_no_ack", {30'd0, a_ack1, a_ack0}, 32'd0);
        PRESET = 0;
        tick();

        // Contention: both held high for four transfers
        req0 = 1; wr0 = 1; addr0 = BASE; wdata0 = 32'hA0A0_A0A0;
        req1 = 1; wr1 = 1; addr1 = BASE + 32'd4; wdata1 = 32'hB1B1_B1B1;
        push(1'b0, 1'b0, 32'd0); push(1'b1, 1'b0, 32'd0);
        push(1'b0, 1'b0, 32'd0); push(1'b1, 1'b0, 32'd0);
        tick();
        chk("rstx_prio_req0", a_paddr, BASE);
        prev = a_psel; nack = 0; viol = 0;
        for (int i = 0; i < 40 && nack < 4; i++) begin
            tick();
            if (a_psel && !a_pen && prev) viol++;
            if (a_pen && !a_psel) viol++;
            if (a_ack0 || a_ack1) nack++;
            prev = a_psel;
        end
        req0 = 0; req1 = 0;
        chk("cont_ack_count", nack, 32'd4);
        chk("cont_psel_spacing", viol, 32'd0);
        tick(); tick();
        chk("cont_sb_empty", sb.size(), 32'd0);
        chk("cont_idle", {31'd0, a_psel}, 32'd0);

        // IDLE_GAP=3 spacing on dut_b
        mon_en = 1'b0;
        PRESET = 1; tick(); tick();
        PRESET = 0; tick();
        req0 = 1; wr0 = 1; addr0 = BASE; wdata0 = 32'h0000_0033;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (b_ack0) found = 1;
        end
        chk("gap_first_ack", {31'd0, found}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b_psel) break;
            cnt++;
        end
        chk("gap_idle_cycles", cnt, 32'd4);
        chk("gap_next_setup", {30'd0, b_psel, b_pen}, 32'd2);
        req0 = 0;
        PRESET = 1; tick();
        chk("b_reset_quiet", {31'd0, |{b_pwrite, b_paddr, b_pwdata, b_err0, b_rdata0,
                                      b_ack1, b_err1, b_rdata1, b_ack0, b_psel}}, 32'd0);
        PRESET = 0; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
